// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// One byte per grant; an optional per-requester lock keeps multi-byte messages contiguous.
module tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WAIT_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_lock,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_tx_go,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GO,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic             lock_valid;
  logic [CNT_W-1:0] cnt;

  logic             lock_hold_c;
  logic             win_vld_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [IDX_W-1:0] ptr_next_c;
  logic [7:0]       win_data_c;

  // Winner selection: a held lock pins the owner, otherwise scan from ptr with wrap
  always_comb begin
    lock_hold_c = lock_valid && i_lock[owner];
    win_vld_c   = 1'b0;
    win_idx_c   = ptr;
    if (lock_hold_c) begin
      win_vld_c = i_req[owner];
      win_idx_c = owner;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_vld_c && i_req[IDX_W'((32'(ptr) + i) % NUM_REQ)]) begin
          win_vld_c = 1'b1;
          win_idx_c = IDX_W'((32'(ptr) + i) % NUM_REQ);
        end
      end
    end
  end

  // Byte mux and pointer advance for the selected requester
  always_comb begin
    win_data_c = 8'h00;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == win_idx_c) begin
        win_data_c = i_data[8*k +: 8];
      end
    end
    ptr_next_c = (win_idx_c == IDX_LAST) ? '0 : IDX_W'(win_idx_c + IDX_W'(1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      lock_valid <= 1'b0;
      cnt        <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_tx_go    <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_ack   <= '0;
      o_tx_go <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lock_valid && !i_lock[owner]) begin
            lock_valid <= 1'b0;
          end
          if (i_tx_ready && win_vld_c) begin
            o_grant    <= ONE_HOT0 << win_idx_c;
            o_ack      <= ONE_HOT0 << win_idx_c;
            o_tx_data  <= win_data_c;
            o_tx_go    <= 1'b1;
            o_busy     <= 1'b1;
            lock_valid <= i_lock[win_idx_c];
            owner      <= win_idx_c;
            ptr        <= ptr_next_c;
            state      <= ST_GO;
          end
        end
        ST_GO: begin
          cnt   <= '0;
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!i_tx_ready) begin
            state <= ST_WAIT_HIGH;
          end else if (cnt == CNT_LAST) begin
            // Transmitter never accepted the byte: drop it and free the channel
            o_err      <= 1'b1;
            lock_valid <= 1'b0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (i_tx_ready) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a simple UART transmitter ready model.
module tb_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned WAIT_TIMEOUT = 8;
  localparam int unsigned BAUD_DIV     = 4;
  localparam int          FRAME_CYC    = BAUD_DIV * 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_go;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int tx_mode = 0;  // 0 normal transmitter, 1 ready stuck high, 2 ready forced low
  logic model_ready;
  int   model_cnt;

  tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_lock     (lock),
    .i_data     (data),
    .o_ack      (ack),
    .o_grant    (grant),
    .o_tx_go    (tx_go),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  assign tx_ready = (tx_mode == 2) ? 1'b0 : model_ready;

  // Transmitter: ready drops the cycle after go and stays low for one frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_ready <= 1'b1;
      model_cnt   <= 0;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_ready <= 1'b1;
    end else if (tx_go && tx_mode == 0) begin
      model_ready <= 1'b0;
      model_cnt   <= FRAME_CYC;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_go(input string tag);
    int i = 0;
    while (tx_go !== 1'b1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(tx_go), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy !== 1'b0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] eg;
    int         n;

    // 1: reset with all requests pending
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    data  = 32'hA3A2A1A0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_go", 32'(tx_go), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_ack", 32'(ack), 32'h1);
    chk("first_go", 32'(tx_go), 32'h1);
    chk("first_data", 32'(tx_data), 32'hA0);
    chk("first_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("first_ack_clr", 32'(ack), 32'h0);
    chk("first_go_clr", 32'(tx_go), 32'h0);
    chk("first_grant_hold", 32'(grant), 32'h1);

    // 2: steady requests rotate 1,2,3,0,1
    for (int i = 1; i <= 5; i++) begin
      wait_go("rr_go");
      eg = 4'b0001 << (i % 4);
      chk("rr_grant", 32'(grant), 32'(eg));
      chk("rr_ack", 32'(ack), 32'(eg));
      chk("rr_data", 32'(tx_data), 32'(8'hA0 + 8'(i % 4)));
      if (i == 5) req = 4'b0000;
      @(negedge clk);
      if (i == 1) begin
        repeat (5) @(negedge clk);
        chk("rr_data_stable", 32'(tx_data), 32'hA1);
      end
    end
    wait_idle("rr_idle");

    // 3: locked requester 2 sends three bytes before requester 1 is served
    data[23:16] = 8'h41;
    req  = 4'b0110;
    lock = 4'b0100;
    wait_go("lock_go0");
    chk("lock_grant0", 32'(grant), 32'h4);
    chk("lock_data0", 32'(tx_data), 32'h41);
    data[23:16] = 8'h42;
    repeat (4) @(negedge clk);
    chk("lock_data0_stable", 32'(tx_data), 32'h41);
    wait_go("lock_go1");
    chk("lock_grant1", 32'(grant), 32'h4);
    chk("lock_data1", 32'(tx_data), 32'h42);
    data[23:16] = 8'h43;
    @(negedge clk);
    wait_go("lock_go2");
    chk("lock_grant2", 32'(grant), 32'h4);
    chk("lock_data2", 32'(tx_data), 32'h43);
    lock = 4'b0000;
    req  = 4'b0010;
    @(negedge clk);
    wait_go("unlock_go");
    chk("unlock_grant", 32'(grant), 32'h2);
    chk("unlock_data", 32'(tx_data), 32'hA1);
    req = 4'b0000;
    @(negedge clk);
    wait_idle("lock_idle");

    // 4: transmitter never drops ready -> timeout error
    tx_mode = 1;
    req = 4'b0001;
    wait_go("to_go");
    chk("to_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    n = 0;
    while (err !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_err_delay", 32'(n), 32'd9);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_grant_clr", 32'(grant), 32'h0);
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 32'h0);
    tx_mode = 0;
    req = 4'b0010;
    wait_go("to_next_go");
    chk("to_next_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    wait_idle("to_idle");

    // 5: asynchronous reset during WAIT_HIGH
    req = 4'b1000;
    wait_go("ar_go");
    chk("ar_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("ar_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_grant_rst", 32'(grant), 32'h0);
    chk("ar_busy_rst", 32'(busy), 32'h0);
    chk("ar_data_rst", 32'(tx_data), 32'h0);
    chk("ar_go_rst", 32'(tx_go), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_no_go", 32'(tx_go), 32'h0);
    end
    req = 4'b1111;
    wait_go("ar_ptr_go");
    chk("ar_ptr_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    wait_idle("ar_idle");

    // 6: transmitter not ready in IDLE holds off the grant
    tx_mode = 2;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("nr_no_ack", 32'(ack), 32'h0);
    end
    tx_mode = 0;
    @(negedge clk);
    chk("nr_go", 32'(tx_go), 32'h1);
    chk("nr_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    wait_idle("nr_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
